// File: rtl/shift_pkg.sv
// Types and defaults shared by the dual shift-register stage.
package shift_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE,
    HOLD
  } state_t;

endpackage

// File: rtl/shift_reg_cell.sv
// One parallel-load, right-shifting register; the serial output is the LSB.
module shift_reg_cell
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out
);

  // A shift always wins over a load; the top never asserts both anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {serial_in, q[WIDTH-1:1]};
    end else if (load) begin
      q <= d;
    end
  end

  assign serial_out = q[0];

endmodule

// File: rtl/shift_reg_unit.sv
// Dual A/B shift-register stage: parallel loads in IDLE, and on Execute a
// WIDTH-position right shift of {A,B} sequenced by a small Moore FSM.
module shift_reg_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] D,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic             Execute,
  input  logic             Shift_In,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Shift_Out,
  output logic             Busy,
  output logic             Done
);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             shift_en;
  logic             load_a;
  logic             load_b;
  logic             a_to_b;
  logic             b_out;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // HOLD keeps a still-pressed Execute from starting another operation.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (Execute) state_next = SHIFT;
      SHIFT: if (cnt == CNT_W'(WIDTH - 1)) state_next = DONE;
      DONE:  state_next = Execute ? HOLD : IDLE;
      HOLD:  if (!Execute) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (state == IDLE && Execute) begin
      cnt <= '0;
    end else if (state == SHIFT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Execute takes priority over loads in IDLE.
  assign shift_en = (state == SHIFT);
  assign load_a   = (state == IDLE) && !Execute && LoadA;
  assign load_b   = (state == IDLE) && !Execute && LoadB;

  shift_reg_cell #(.WIDTH(WIDTH)) u_reg_a (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .load      (load_a),
    .shift_en  (shift_en),
    .d         (D),
    .serial_in (Shift_In),
    .q         (A),
    .serial_out(a_to_b)
  );

  shift_reg_cell #(.WIDTH(WIDTH)) u_reg_b (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .load      (load_b),
    .shift_en  (shift_en),
    .d         (D),
    .serial_in (a_to_b),
    .q         (B),
    .serial_out(b_out)
  );

  assign Shift_Out = b_out;
  assign Busy      = (state == SHIFT);
  assign Done      = (state == DONE);

endmodule

// File: tb/tb_shift_reg_unit.sv
// Directed and random bench for shift_reg_unit against a 16-bit {A,B} reference model.
module tb_shift_reg_unit;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [7:0] D;
  logic       LoadA, LoadB, Execute, Shift_In;
  logic [7:0] A, B;
  logic       Shift_Out, Busy, Done;

  int checks = 0;
  int errors = 0;

  // Reference model: the concatenation {A,B} plus operation bookkeeping.
  logic [15:0] m_ab;
  int          m_left;
  bit          m_done;
  bit          m_wait;

  shift_reg_unit #(.WIDTH(8), .CNT_W(3)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .D        (D),
    .LoadA    (LoadA),
    .LoadB    (LoadB),
    .Execute  (Execute),
    .Shift_In (Shift_In),
    .A        (A),
    .B        (B),
    .Shift_Out(Shift_Out),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ab   = '0;
    m_left = 0;
    m_done = 0;
    m_wait = 0;
  endtask

  // One clock edge of behaviour, using the inputs currently applied.
  task automatic model_edge();
    if (m_left > 0) begin
      m_ab   = {Shift_In, m_ab[15:1]};
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else if (m_done) begin
      m_done = 0;
      m_wait = Execute;
    end else if (m_wait) begin
      m_wait = Execute;
    end else if (Execute) begin
      m_left = 8;
    end else begin
      if (LoadA) m_ab[15:8] = D;
      if (LoadB) m_ab[7:0]  = D;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".A"},    {8'h00, A},          {8'h00, m_ab[15:8]});
    check({tag, ".B"},    {8'h00, B},          {8'h00, m_ab[7:0]});
    check({tag, ".Busy"}, {15'h0, Busy},       {15'h0, 1'(m_left > 0)});
    check({tag, ".Done"}, {15'h0, Done},       {15'h0, m_done});
    check({tag, ".SOut"}, {15'h0, Shift_Out},  {15'h0, m_ab[0]});
  endtask

  task automatic step(input string tag, input logic la, input logic lb,
                      input logic ex, input logic si, input logic [7:0] d);
    LoadA = la; LoadB = lb; Execute = ex; Shift_In = si; D = d;
    @(posedge Clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    check({tag, ".A"},    {8'h00, A},   16'h0000);
    check({tag, ".B"},    {8'h00, B},   16'h0000);
    check({tag, ".Busy"}, {15'h0, Busy}, 16'h0000);
    check({tag, ".Done"}, {15'h0, Done}, 16'h0000);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    int busy_cnt, done_cnt;
    logic [7:0] sout_seq;

    Reset_n = 1'b0; D = '0; LoadA = 0; LoadB = 0; Execute = 0; Shift_In = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    compare_all("reset");
    @(negedge Clk);
    Reset_n = 1'b1;

    // Load 0x33/0x55, zero fill
    step("s2.ldA", 1, 0, 0, 0, 8'h33);
    step("s2.ldB", 0, 1, 0, 0, 8'h55);
    step("s2.ex",  0, 0, 1, 0, 8'h00);
    busy_cnt = Busy; done_cnt = Done;
    for (int i = 0; i < 9; i++) begin
      step("s2.sh", 0, 0, 0, 0, 8'h00);
      busy_cnt += Busy;
      done_cnt += Done;
      if (i == 7) begin
        check("s2.finalA", {8'h00, A}, 16'h0000);
        check("s2.finalB", {8'h00, B}, 16'h0033);
      end
    end
    check("s2.busy_cycles", 16'(busy_cnt), 16'd8);
    check("s2.done_pulses", 16'(done_cnt), 16'd1);

    // Same loads, one fill; Shift_Out shows 0x55 LSB first
    step("s3.ldA", 1, 0, 0, 1, 8'h33);
    step("s3.ldB", 0, 1, 0, 1, 8'h55);
    step("s3.ex",  0, 0, 1, 1, 8'h00);
    sout_seq = '0;
    for (int i = 0; i < 8; i++) begin
      sout_seq[i] = Shift_Out;
      step("s3.sh", 0, 0, 0, 1, 8'h00);
    end
    check("s3.sout_seq", {8'h00, sout_seq}, 16'h0055);
    check("s3.finalA", {8'h00, A}, 16'h00FF);
    check("s3.finalB", {8'h00, B}, 16'h0033);
    step("s3.idle", 0, 0, 0, 0, 8'h00);

    // Asynchronous reset with A,B nonzero
    async_reset("s1.async");

    // Execute held for 20 cycles: one operation, then a second press
    step("s4.ldA", 1, 0, 0, 0, 8'hA7);
    step("s4.ldB", 0, 1, 0, 0, 8'h3C);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step("s4.hold", 1, 1, 1, i[0], 8'hFF);
      done_cnt += Done;
    end
    check("s4.done_pulses", 16'(done_cnt), 16'd1);
    step("s4.rel", 0, 0, 0, 0, 8'h00);
    step("s4.rel", 0, 0, 0, 0, 8'h00);
    done_cnt = 0;
    step("s4.ex2", 0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step("s4.sh2", 0, 0, 0, 1, 8'h00);
      done_cnt += Done;
    end
    check("s4.second_done", 16'(done_cnt), 16'd1);

    // Conflicts: LoadA with Execute in IDLE, LoadB during SHIFT
    step("s5.ex_ldA", 1, 0, 1, 0, 8'h99);
    for (int i = 0; i < 9; i++) step("s5.ldB_sh", 0, 1, 0, 1, 8'hC3);
    step("s5.idle", 0, 0, 0, 0, 8'h00);

    // Abort after 4 shifts, then a full operation
    step("s6.ldA", 1, 1, 0, 0, 8'h6B);
    step("s6.ex",  0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) step("s6.sh", 0, 0, 0, 1, 8'h00);
    async_reset("s6.abort");
    step("s6.post", 0, 0, 0, 0, 8'h00);
    step("s6.ldA2", 1, 0, 0, 0, 8'hE1);
    step("s6.ex2",  0, 0, 1, 0, 8'h00);
    done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      busy_cnt += Busy;
      step("s6.sh2", 0, 0, 0, 0, 8'h00);
      done_cnt += Done;
    end
    check("s6.busy_cycles", 16'(busy_cnt), 16'd8);
    check("s6.done_pulses", 16'(done_cnt), 16'd1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_unit.md
Name: shift_reg_unit

Overview:
Dual shift-register stage directly downstream of the 8-bit 2:1 data-select mux in the serial logic processor datapath. Captures the mux output into register A or B on a load strobe. On an Execute request, shifts the concatenated {A,B} right by exactly WIDTH positions under control of an internal FSM. A and B feed back to the mux data inputs and to the serial compute stage.

Parameters:
WIDTH, 8, bit width of each of registers A and B; the shift count equals WIDTH.
CNT_W, 3, shift-counter width, equal to $clog2(WIDTH).

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Reset_n  input  1  asynchronous active-low reset.
D  input  WIDTH  parallel load data (the mux Z output).
LoadA  input  1  load D into A (level, sampled each edge).
LoadB  input  1  load D into B (level, sampled each edge).
Execute  input  1  start an 8-shift operation (level; retriggers only after release).
Shift_In  input  1  serial bit entering A[WIDTH-1] on each shift.
A  output  WIDTH  register A contents.
B  output  WIDTH  register B contents.
Shift_Out  output  1  equals B[0] (combinational).
Busy  output  1  high while in SHIFT.
Done  output  1  one-cycle pulse after the final shift.

Behaviour:
- Clock and reset (already decided): one clock, Clk; reset is asynchronous and active-low, Reset_n.
- Reset state: A=0, B=0, Busy=0, Done=0, counter=0, state=IDLE. Assertion mid-operation aborts immediately, with no partial completion and no Done.
- FSM states: IDLE, SHIFT, DONE, HOLD. Busy and Done are decoded from the state (Moore outputs).
- IDLE, Execute=1 at an edge:
  - next state SHIFT, counter cleared to 0.
  - Execute has priority: LoadA and LoadB are ignored on that edge.
- IDLE, Execute=0 at an edge:
  - LoadA=1 loads A<=D; LoadB=1 loads B<=D.
  - Both high loads both from the same D.
- SHIFT, at each edge:
  - A <= {Shift_In, A[WIDTH-1:1]}
  - B <= {A[0], B[WIDTH-1:1]}
  - counter increments.
  - On the edge where counter==WIDTH-1 (the 8th shift), next state is DONE.
- Loads are ignored in SHIFT, DONE and HOLD. Execute level is ignored in SHIFT.
- Latency: Execute sampled at edge k gives shifts on edges k+1..k+WIDTH. Done=1 for the cycle following edge k+WIDTH.
- DONE: lasts one cycle. Next state HOLD if Execute=1, else IDLE.
- HOLD: stays until Execute=0, then IDLE. Prevents retrigger while the button stays pressed.
- Counter wraps naturally at 2^CNT_W; the FSM never lets it exceed WIDTH-1.
- Shift_In is sampled every SHIFT edge; a change mid-operation takes effect on the next shift.
- Registers hold their value in all states except load and shift as stated above.

Decomposition:
- Shared package shift_pkg:
  - state_t enum {IDLE, SHIFT, DONE, HOLD}
  - default WIDTH constant.
- One natural sub-module: shift_reg_cell, a WIDTH-bit register with load, shift_en, serial_in and serial_out. It is instantiated twice and chained A.serial_out -> B.serial_in.
- The FSM and counter stay in the top.

Test Plan:
1. Reset: assert Reset_n=0 mid-cycle with A,B nonzero -> A=0x00, B=0x00, Busy=0, Done=0 immediately (asynchronous), without waiting for a clock edge.
2. Load and shift, zero fill: D=0x33 with LoadA, then D=0x55 with LoadB, Shift_In=0, pulse Execute -> Busy=1 for exactly 8 cycles; final A=0x00, B=0x33; Done high for 1 cycle.
3. Load and shift, one fill: same loads as scenario 2, Shift_In=1 -> final A=0xFF, B=0x33. Check Shift_Out sequence = 1,0,1,0,1,0,1,0, the bits of 0x55 LSB first.
4. Execute held: hold Execute high 20 cycles -> exactly one 8-shift operation, FSM in HOLD until release. A second Execute press then performs a second operation.
5. Conflicting inputs: LoadA=1 with Execute=1 in IDLE -> A not loaded, shift starts. LoadB=1 during SHIFT -> B unaffected by D.
6. Abort: Reset_n asserted after 4 shifts -> all zero, state IDLE, no Done pulse; the next Execute runs a full 8 shifts.
